wb_stage: RTL

Final pipeline stage. Consumes the memory-stage bus and commits its result to the register file. Owns the exception and interrupt subset of CP0: BadVAddr, Count, Compare, Status, Cause and EPC. Raises the pipeline flush and redirect PC on exception or eret, and drives the forwarding bus and the debug trace.

---
 rtl/wb_stage_if.sv | 9 +
 rtl/wb_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/wb_stage_if.sv
// Memory-stage to write-back handshake: valid/bus from MS, allowin back from WB.
interface wb_stage_if;
  logic         ms_to_ws_valid;
  logic [130:0] ms_to_ws_bus;
  logic         ws_allowin;

  modport master (output ms_to_ws_valid, output ms_to_ws_bus, input  ws_allowin);
  modport slave  (input  ms_to_ws_valid, input  ms_to_ws_bus, output ws_allowin);
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: register-file commit, CP0 exception/interrupt subset, flush/redirect, trace.
// Optional macro WB_TIMER_INT_EN: Count ticks at half clock rate and raises Cause.TI on Compare match.
module wb_stage #(
  parameter logic [31:0] EX_ENTRY     = 32'hBFC00380,
  parameter logic [31:0] REFILL_ENTRY = 32'hBFC00200
) (
  input  logic        clk,
  input  logic        resetn,
  wb_stage_if.slave   ms,
  input  logic [5:0]  ext_int_in,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [37:0] stall_ws_bus,
  output logic        ws_ex,
  output logic        ws_eret,
  output logic [31:0] ws_flush_pc,
  output logic        ws_int_pending,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);
  localparam logic [7:0] A_BADV = 8'h40, A_COUNT = 8'h48, A_CMP = 8'h58,
                         A_STAT = 8'h60, A_CAUSE = 8'h68, A_EPC = 8'h70;

  logic         ws_valid;
  logic [130:0] bus;

  logic        f_refill, f_eret, f_bd, f_exc, f_cp0_op, f_cp0_we, f_gr_we;
  logic [31:0] f_badv, f_result, f_pc;
  logic [4:0]  f_code, f_dest;
  logic [7:0]  f_addr;
  assign f_refill = bus[130];
  assign f_eret   = bus[121];
  assign f_badv   = bus[120:89];
  assign f_bd     = bus[88];
  assign f_exc    = bus[87];
  assign f_code   = bus[86:82];
  assign f_cp0_op = bus[81];
  assign f_cp0_we = bus[80];
  assign f_addr   = bus[79:72];
  assign f_gr_we  = bus[69];
  assign f_dest   = bus[68:64];
  assign f_result = bus[63:32];
  assign f_pc     = bus[31:0];

  logic unused_bus;
  assign unused_bus = ^{bus[129:122], bus[71:70]};

  assign ms.ws_allowin = 1'b1;

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) ws_valid <= 1'b0;
    else         ws_valid <= ms.ms_to_ws_valid & ~(ws_ex | ws_eret);

  always_ff @(posedge clk)
    if (ms.ms_to_ws_valid) bus <= ms.ms_to_ws_bus;

  // CP0 state, stored as the writable/updated fields only
  logic [31:0] badvaddr, count, compare, epc;
  logic [7:0]  st_im;
  logic        st_exl, st_ie;
  logic        ca_bd;
  logic [5:0]  ca_ip_hw;
  logic [1:0]  ca_ip_sw;
  logic [4:0]  ca_code;

  logic exc, mtc0_we, cnt_wr, cmp_wr;
  assign exc     = ws_valid & f_exc;
  assign mtc0_we = ws_valid & f_cp0_we & ~f_exc;
  assign cnt_wr  = mtc0_we & (f_addr == A_COUNT);
  assign cmp_wr  = mtc0_we & (f_addr == A_CMP);

`ifdef WB_TIMER_INT_EN
  logic ca_ti, tick;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      tick  <= 1'b0;
      ca_ti <= 1'b0;
    end else begin
      tick <= ~tick;
      if (cmp_wr)                ca_ti <= 1'b0;
      else if (count == compare) ca_ti <= 1'b1;
    end
`else
  logic ca_ti;
  assign ca_ti = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      count   <= 32'd0;
      compare <= 32'd0;
    end else begin
      if (cnt_wr) count <= f_result;
`ifdef WB_TIMER_INT_EN
      else if (tick) count <= count + 32'd1;
`endif
      if (cmp_wr) compare <= f_result;
    end

  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      badvaddr <= 32'd0;
      epc      <= 32'd0;
      st_im    <= 8'd0;
      st_exl   <= 1'b0;
      st_ie    <= 1'b0;
      ca_bd    <= 1'b0;
      ca_ip_hw <= 6'd0;
      ca_ip_sw <= 2'd0;
      ca_code  <= 5'd0;
    end else begin
      ca_ip_hw <= ext_int_in;
      if (exc) begin
        // nested exceptions keep the original EPC/BD
        if (!st_exl) begin
          epc   <= f_bd ? f_pc - 32'd4 : f_pc;
          ca_bd <= f_bd;
        end
        st_exl  <= 1'b1;
        ca_code <= f_code;
        if (f_code >= 5'd1 && f_code <= 5'd5) badvaddr <= f_badv;
      end else begin
        if (ws_eret) st_exl <= 1'b0;
        if (mtc0_we)
          case (f_addr)
            A_STAT: begin
              st_im  <= f_result[15:8];
              st_exl <= f_result[1];
              st_ie  <= f_result[0];
            end
            A_CAUSE: ca_ip_sw <= f_result[9:8];
            A_EPC:   epc      <= f_result;
            default: ;
          endcase
      end
    end

  logic [7:0]  cause_ip;
  logic [31:0] status_rd, cause_rd, cp0_rdata;
  assign cause_ip  = {ca_ip_hw[5] | ca_ti, ca_ip_hw[4:0], ca_ip_sw};
  assign status_rd = {9'd0, 1'b1, 6'd0, st_im, 6'd0, st_exl, st_ie};
  assign cause_rd  = {ca_bd, ca_ti, 14'd0, cause_ip, 1'b0, ca_code, 2'b00};

  always_comb begin
    cp0_rdata = 32'd0;
    case (f_addr)
      A_BADV:  cp0_rdata = badvaddr;
      A_COUNT: cp0_rdata = count;
      A_CMP:   cp0_rdata = compare;
      A_STAT:  cp0_rdata = status_rd;
      A_CAUSE: cp0_rdata = cause_rd;
      A_EPC:   cp0_rdata = epc;
      default: cp0_rdata = 32'd0;
    endcase
  end

  assign ws_ex    = exc;
  assign ws_eret  = ws_valid & f_eret & ~f_exc;
  assign rf_we    = ws_valid & f_gr_we & ~f_exc;
  assign rf_waddr = ws_valid ? f_dest : 5'd0;
  assign rf_wdata = !ws_valid ? 32'd0 : (f_cp0_op & ~f_cp0_we) ? cp0_rdata : f_result;

  assign stall_ws_bus   = {ws_valid & f_gr_we, rf_waddr, rf_wdata};
  assign ws_flush_pc    = ws_eret ? epc : (ws_ex & f_refill) ? REFILL_ENTRY : EX_ENTRY;
  assign ws_int_pending = st_ie & ~st_exl & |(cause_ip & st_im);

  assign debug_wb_pc       = ws_valid ? f_pc : 32'd0;
  assign debug_wb_rf_wen   = {4{rf_we}};
  assign debug_wb_rf_wnum  = rf_waddr;
  assign debug_wb_rf_wdata = rf_wdata;
endmodule
